// File: rtl/flight_ctrl_pkg.sv
// Shared types and IMU frame layout for the flight-control sensor path.
package flight_ctrl_pkg;

  typedef enum logic {
    IDLE,
    READING
  } state_t;

  localparam int IMU_NUM_CH      = 6;
  localparam int IMU_FRAME_BYTES = 14;

  localparam logic [IMU_NUM_CH*8-1:0] IMU_CH_OFFSETS =
    {8'd12, 8'd10, 8'd8, 8'd4, 8'd2, 8'd0};

endpackage

// File: rtl/edge_sync.sv
// Multi-stage synchroniser followed by a rising-edge detector.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign rise = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/sensor_frame_collector.sv
// Triggers I2C burst reads and unpacks the returned bytes into channel words.
module sensor_frame_collector
  import flight_ctrl_pkg::*;
#(
  parameter int                    NUM_CH         = IMU_NUM_CH,
  parameter int                    CH_BYTES       = 2,
  parameter int                    FRAME_BYTES    = IMU_FRAME_BYTES,
  parameter logic [NUM_CH*8-1:0]   CH_OFFSETS     = IMU_CH_OFFSETS,
  parameter bit                    BIG_ENDIAN     = 1'b1,
  parameter int                    SYNC_STAGES    = 2,
  parameter int                    TIMEOUT_CYCLES = 65535
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         TRIG,
  input  logic [7:0]                   RD_DATA,
  input  logic                         RD_VALID,
  input  logic                         BUSY,
  output logic                         RD_EN,
  output logic [7:0]                   SAMPLE_INDEX,
  output logic [NUM_CH*CH_BYTES*8-1:0] CH_DATA,
  output logic [NUM_CH-1:0]            CH_VALID,
  output logic                         FRAME_VALID,
  output logic                         OVERRUN,
  output logic                         TIMEOUT,
  output logic                         SHORT_FRAME,
  output logic [7:0]                   ERR_COUNT
);

  localparam int W = CH_BYTES * 8;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chk
    if (int'(CH_OFFSETS[g*8+:8]) + CH_BYTES > FRAME_BYTES) begin : g_bad
      $error("channel slot extends past end of frame");
    end
  end

  logic trig_edge;

  edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_trig_sync (
    .CLK  (CLK),
    .RST  (RST),
    .din  (TRIG),
    .rise (trig_edge)
  );

  state_t                  state_q, state_d;
  logic                    rd_en_q, rd_en_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [15:0]             timer_q, timer_d;
  logic [7:0]              idx_q, idx_d;
  logic [NUM_CH*W-1:0]     data_q, data_d;
  logic [NUM_CH-1:0]       chv_q, chv_d;
  logic                    fv_q, fv_d;
  logic                    ovr_q, ovr_d;
  logic                    to_q, to_d;
  logic                    short_q, short_d;
  logic [7:0]              err_q, err_d;
  logic                    rdv_q, rdv_d;
  logic                    busy_q, busy_d;
  logic                    strobe, busy_fall;
  logic [8:0]              err_sum;

  assign strobe    = RD_VALID & ~rdv_q;
  assign busy_fall = busy_q & ~BUSY;

  always_comb begin
    state_d = state_q;
    rd_en_d = rd_en_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    data_d  = data_q;
    chv_d   = '0;
    fv_d    = 1'b0;
    ovr_d   = 1'b0;
    to_d    = 1'b0;
    short_d = 1'b0;
    rdv_d   = RD_VALID;
    busy_d  = BUSY;
    err_sum = '0;

    unique case (state_q)
      IDLE: begin
        if (trig_edge) begin
          state_d = READING;
          rd_en_d = 1'b1;
          cnt_d   = '0;
          timer_d = '0;
          idx_d   = idx_q + 8'd1;
        end
      end
      READING: begin
        timer_d = timer_q + 16'd1;
        if (trig_edge) begin
          // A coincident BUSY fall closes the old frame cleanly.
          short_d = busy_fall && (int'(cnt_q) < FRAME_BYTES);
          ovr_d   = ~busy_fall;
          rd_en_d = 1'b1;
          cnt_d   = '0;
          timer_d = '0;
          idx_d   = idx_q + 8'd1;
        end else begin
          if (strobe && int'(cnt_q) < FRAME_BYTES) begin
            for (int i = 0; i < NUM_CH; i++) begin
              for (int k = 0; k < CH_BYTES; k++) begin
                if (int'(cnt_q) == int'(CH_OFFSETS[i*8+:8]) + k) begin
                  data_d[i*W + (BIG_ENDIAN ? CH_BYTES-1-k : k)*8 +: 8]
                    = RD_DATA;
                end
              end
              chv_d[i] = int'(cnt_q) ==
                         int'(CH_OFFSETS[i*8+:8]) + CH_BYTES - 1;
            end
            fv_d  = int'(cnt_q) == FRAME_BYTES - 1;
            cnt_d = cnt_q + 8'd1;
          end
          if (busy_fall) begin
            state_d = IDLE;
            rd_en_d = 1'b0;
            short_d = int'(cnt_d) < FRAME_BYTES;
          end else if (int'(timer_q) == TIMEOUT_CYCLES - 1) begin
            state_d = IDLE;
            rd_en_d = 1'b0;
            to_d    = 1'b1;
          end
        end
      end
    endcase

    err_sum = {1'b0, err_q} + 9'(ovr_d) + 9'(to_d) + 9'(short_d);
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      cnt_q   <= '0;
      timer_q <= '0;
      idx_q   <= 8'hFF;
      data_q  <= '0;
      chv_q   <= '0;
      fv_q    <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
      short_q <= 1'b0;
      err_q   <= '0;
      rdv_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      chv_q   <= chv_d;
      fv_q    <= fv_d;
      ovr_q   <= ovr_d;
      to_q    <= to_d;
      short_q <= short_d;
      err_q   <= err_d;
      rdv_q   <= rdv_d;
      busy_q  <= busy_d;
    end
  end

  assign RD_EN        = rd_en_q;
  assign SAMPLE_INDEX = idx_q;
  assign CH_DATA      = data_q;
  assign CH_VALID     = chv_q;
  assign FRAME_VALID  = fv_q;
  assign OVERRUN      = ovr_q;
  assign TIMEOUT      = to_q;
  assign SHORT_FRAME  = short_q;
  assign ERR_COUNT    = err_q;

endmodule
